// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with HI/LO result registers and MTHI/MTLO write access.
module mips_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_diff;
    logic [2*WIDTH-1:0]   mul_step, div_step, prod;
    logic [WIDTH-1:0]     quot, rem;

    assign a_neg = ~op[0] & operand_a[WIDTH-1];
    assign b_neg = ~op[0] & operand_b[WIDTH-1];
    assign mag_a = a_neg ? -operand_a : operand_a;
    assign mag_b = b_neg ? -operand_b : operand_b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    assign div_step = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d   = op;
                    dbz_d  = 1'b0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = CW'(WIDTH);
                    if (op[1]) begin
                        m_d   = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        m_d   = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                    state_d = (op[1] && operand_b == '0) ? StFinish : StCalc;
                end else begin
                    if (mt_hi) hi_d = operand_a;
                    if (mt_lo) lo_d = operand_a;
                end
            end
            StCalc: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
                // A zero divisor leaves m_q at zero; only real divides reach here with m_q != 0.
                if (op_q[1] && m_q == '0) begin
                    dbz_d = 1'b1;
                end else if (op_q[1]) begin
                    lo_d = quot;
                    hi_d = rem;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected HI/LO/div_by_zero pushed at issue, popped on done.
module tb_mips_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .mt_hi(mt_hi), .mt_lo(mt_lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_, ua, ub, p, q, r;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        e.dbz = 1'b0;
        e.hi  = model_hi;
        e.lo  = model_lo;
        case (o)
            2'b00: begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    e.dbz = 1'b1;
                end else begin
                    if (o == 2'b10) begin q = sa / sb_; r = sa % sb_; end
                    else begin q = ua / ub; r = ua % ub; end
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Issue one operation at a falling edge and wait (bounded) for its done pulse.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input bit with_mt);
        exp_t e, got;
        int   cyc, bcnt, lat;
        e = model(o, a, b);
        sb.push_back(e);
        lat = e.dbz ? 1 : 33;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        mt_hi = with_mt; mt_lo = with_mt;
        @(negedge clk);
        start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        operand_a = $urandom; operand_b = $urandom; op = 2'($urandom_range(0, 3));
        cyc = 0; bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            if (cyc == 5 && disturb) begin
                start = 1'b1; mt_hi = 1'b1; mt_lo = 1'b1;
            end else begin
                start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
            end
            if (cyc == 16 && !e.dbz) check("hold_during_calc", {hi, lo}, {model_hi, model_lo});
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        check("latency", 64'(cyc), 64'(lat));
        check("busy_cycles", 64'(bcnt), 64'(lat));
        check("busy_after_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            check("hi", 64'(hi), 64'(got.hi));
            check("lo", 64'(lo), 64'(got.lo));
            check("div_by_zero", 64'(div_by_zero), 64'(got.dbz));
            model_hi = got.hi;
            model_lo = got.lo;
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        operand_a = 32'h0000_1234; mt_lo = 1'b1;
        @(negedge clk);
        mt_lo = 1'b0;
        model_lo = 32'h0000_1234;
        check("mtlo", 64'(lo), 64'(model_lo));
        // start wins over a simultaneous move; zero divisor leaves HI/LO as they were.
        do_op(2'b10, 32'h0000_DEAD, 32'h0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("dbz_sticky", 64'(div_by_zero), 64'd1);
        do_op(2'b11, 32'd9, 32'd0, 1'b0, 1'b0);

        operand_a = 32'hCAFE_F00D; mt_hi = 1'b1; mt_lo = 1'b1;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        model_hi = 32'hCAFE_F00D; model_lo = 32'hCAFE_F00D;
        check("mt_both", {hi, lo}, {model_hi, model_lo});
        do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom >> $urandom_range(0, 30));
            do_op(ro, ra, rb, i[0], 1'b0);
        end

        operand_a = 32'h5555_AAAA; mt_hi = 1'b1;
        @(negedge clk);
        mt_hi = 1'b0;
        start = 1'b1; op = 2'b00; operand_a = 32'd123; operand_b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_done_dbz", {done, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_abort", 64'(ndone), 64'd0);
        check("hilo_after_abort", {hi, lo}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath. It consumes the two register-file read ports (rs on `operand_a`, rt on `operand_b`) and executes MULT, MULTU, DIV and DIVU with one bit per cycle. The HI and LO outputs feed the MFHI/MFLO writeback path into the register file. `busy` stalls issue of dependent instructions.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an operation; sampled only while idle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  WIDTH  rs value (multiplicand or dividend); also the source for MTHI/MTLO.
- `operand_b`  in  WIDTH  rt value (multiplier or divisor).
- `mt_hi`  in  1  write `operand_a` into HI (MTHI).
- `mt_lo`  in  1  write `operand_a` into LO (MTLO).
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when a result has been committed.
- `div_by_zero`  out  1  the last accepted DIV/DIVU had divisor 0.
- `hi`  out  WIDTH  HI register: upper product word or remainder.
- `lo`  out  WIDTH  LO register: lower product word or quotient.

## Operation
States:
- **IDLE**
  - `start`=1 latches `op` and the operands, and clears `div_by_zero`.
  - Divide with `operand_b`=0 → FINISH.
  - Otherwise → CALC, with the iteration counter set to `WIDTH`.
- **CALC**: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes. When the counter reaches 0 → FINISH.
- **FINISH**
  - Applies the signs, writes HI/LO, pulses `done`, → IDLE.
  - Divide-by-zero case: HI/LO are left unchanged and `div_by_zero` is set.

Arithmetic rules:
- Signed operations (MULT, DIV) convert both operands to magnitudes using two's-complement negation.
- MULT: the 2·WIDTH-bit product is negated when the operand signs differ. HI gets the upper word, LO the lower word.
- DIV: the quotient sign is sign(a) XOR sign(b); the remainder sign equals sign(a). LO gets the quotient, HI the remainder.
- Unsigned operations use the operands directly with no sign fix-up.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. No other special handling.

Boundary and simultaneous-event rules:
- `start` while busy: ignored. Operand inputs may change freely after acceptance.
- `mt_hi`/`mt_lo` take effect only in IDLE with `start`=0. If `start` is also 1, `start` wins and the moves are dropped. Moves while busy are ignored.
- `mt_hi` and `mt_lo` together write both registers with the same value.
- `div_by_zero` is sticky until the next accepted `start`.
- `rst_n` low at any time, including mid-CALC, aborts immediately. The unit returns to IDLE with HI=0, LO=0, `busy`=0, `done`=0, `div_by_zero`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, state IDLE.
- Let edge E0 be the edge that accepts `start`:
  - `busy` is 1 after E0.
  - CALC iterates on E1..E`WIDTH`.
  - E`WIDTH`+1 commits HI/LO. After that edge `done`=1 for one cycle and `busy`=0.
  - Latency: `WIDTH`+1 cycles (33 by default).
- Divide by zero: FINISH on E1. `done` and `div_by_zero` are 1 after E1; `busy`=0 after E1.
- Back-to-back operations: a new `start` is accepted on the same edge at which `done` rises is not possible, because the FINISH cycle is busy. The earliest next accept is the edge at which `done` falls.
- MTHI/MTLO: the HI/LO output updates after the sampling edge (1-cycle latency).
- HI/LO hold their values during CALC; they are never partially updated.

## Test plan
- **Signed multiply:** MULT a=0xFFFFFFFD (−3), b=5 → after 33 cycles `done` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` high for exactly 33 cycles.
- **Unsigned multiply:** MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **Signed divide:** DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Unsigned divide:** DIVU a=100, b=7 → LO=14, HI=2.
- **Overflow divide:** DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** MTLO 0x1234, then DIV b=0 → `done` and `div_by_zero` one cycle after `start`; LO stays 0x1234.
- **Busy-time rules:** `start` and `mt_hi` pulsed mid-CALC → ignored; result equals the original operation's result.
- **Reset mid-operation:** `rst_n` low at cycle 10 of CALC → `busy`=0 and HI=LO=0 immediately; no `done` pulse follows.
